// File: rtl/lim_brick_wl_scheduler.sv
// Sequential wordline scheduler for one LiM SRAM brick: latches a multi-hot batch and grants one row per handshake.
// Optional build macro LIM_SCHED_RR_EN selects round-robin search from the last grant; default is lowest-index-first.
`ifndef BITS_ADDR_LIM_BRICK
`define BITS_ADDR_LIM_BRICK 5
`endif

module lim_brick_wl_scheduler #(
    parameter int ADDR_WIDTH = `BITS_ADDR_LIM_BRICK,
    parameter int WL_WIDTH   = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WL_WIDTH-1:0]   in_wls,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WL_WIDTH-1:0]   out_wl,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   issued_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WL_WIDTH-1:0]   r_pending;
    logic [WL_WIDTH-1:0]   w_pending_nxt;
    logic [ADDR_WIDTH:0]   r_issued_cnt;
    logic [ADDR_WIDTH:0]   w_issued_cnt_nxt;
    logic [ADDR_WIDTH-1:0] w_grant_idx;
    logic                  w_valid;
    logic                  w_fire;

    function automatic logic [ADDR_WIDTH-1:0] lowest_idx(input logic [WL_WIDTH-1:0] vec);
        logic [ADDR_WIDTH-1:0] idx;
        idx = '0;
        for (int i = WL_WIDTH - 1; i >= 0; i--) begin
            idx = vec[i] ? ADDR_WIDTH'(i) : idx;
        end
        return idx;
    endfunction

    assign w_valid = (r_state == S_ISSUE) && (r_pending != '0);
    assign w_fire  = w_valid && out_ready && !abort;

`ifdef LIM_SCHED_RR_EN
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_start;
    logic [WL_WIDTH-1:0]   w_rot;

    assign w_start = r_ptr + ADDR_WIDTH'(1);

    // Rotate pending so bit 0 of w_rot is the row just after the last grant.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < WL_WIDTH; i++) begin
            w_rot[i] = r_pending[w_start + ADDR_WIDTH'(i)];
        end
    end

    assign w_grant_idx = w_start + lowest_idx(w_rot);

    // Round-robin pointer remembers the last counted grant across batches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= ADDR_WIDTH'(WL_WIDTH - 1);
        end else if (w_fire) begin
            r_ptr <= w_grant_idx;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    assign w_grant_idx = lowest_idx(r_pending);
`endif

    assign in_ready   = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE);
    assign out_valid  = w_valid;
    assign out_addr   = w_valid ? w_grant_idx : '0;
    assign out_wl     = w_valid ? (WL_WIDTH'(1) << w_grant_idx) : '0;
    assign out_last   = w_valid && $onehot(r_pending);
    assign issued_cnt = r_issued_cnt;

    // Next-state logic: batch load, per-grant retirement and abort.
    always_comb begin
        w_state_nxt      = r_state;
        w_pending_nxt    = r_pending;
        w_issued_cnt_nxt = r_issued_cnt;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_pending_nxt    = in_wls;
                    w_issued_cnt_nxt = '0;
                    w_state_nxt      = (in_wls != '0) ? S_ISSUE : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    w_pending_nxt = '0;
                    w_state_nxt   = S_DONE;
                end else if (w_fire) begin
                    w_pending_nxt    = r_pending & ~out_wl;
                    w_issued_cnt_nxt = r_issued_cnt + (ADDR_WIDTH + 1)'(1);
                    w_state_nxt      = $onehot(r_pending) ? S_DONE : S_ISSUE;
                end else if (r_pending == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // State, pending mask and grant counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_issued_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_issued_cnt <= w_issued_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_lim_brick_wl_scheduler.sv
// Scoreboard bench for lim_brick_wl_scheduler; the reference model follows the build's LIM_SCHED_RR_EN setting.
module tb_lim_brick_wl_scheduler;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_wls;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_wl;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        done;
    logic [5:0]  issued_cnt;

    typedef struct {
        int addr;
        bit last;
    } grant_t;

    grant_t exp_q[$];
    int     cnt_q[$];
    int     m_ptr;
    int     vectors;
    int     miscompares;
    bit     done_exp;

    lim_brick_wl_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wls     (in_wls),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_wl     (out_wl),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .done       (done),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the batch's set bits in the order the scheduler must grant them.
    task automatic push_plan(input logic [31:0] wls, input int k_abort, output int n_cnt);
        int          order[$];
        logic [31:0] p;
        int          ptr;
        int          start;
        int          keep;
        p   = wls;
        ptr = m_ptr;
        while (p != 32'd0) begin
`ifdef LIM_SCHED_RR_EN
            start = (ptr + 1) % 32;
`else
            start = 0;
`endif
            for (int k = 0; k < 32; k++) begin
                if (p[(start + k) % 32]) begin
                    order.push_back((start + k) % 32);
                    p[(start + k) % 32] = 1'b0;
                    ptr = (start + k) % 32;
                    break;
                end
            end
        end
        keep = (k_abort >= 0) ? k_abort : order.size();
        for (int i = 0; i < keep; i++) begin
            grant_t g;
            g.addr = order[i];
            g.last = (i == order.size() - 1);
            exp_q.push_back(g);
        end
        if (keep > 0) m_ptr = order[keep - 1];
        cnt_q.push_back(keep);
        n_cnt = keep;
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!in_ready && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        if (!in_ready) begin
            miscompares++;
            $display("FAIL wait_ready: in_ready stayed 0 for %0d cycles", c);
        end
    endtask

    // mode 0: out_ready always 1; mode 1: random out_ready; mode 2: 3-cycle stall then 1.
    task automatic run_batch(input logic [31:0] wls, input int mode, input int k_abort);
        int n;
        int cyc;
        wait_ready();
        push_plan(wls, k_abort, n);
        in_valid = 1'b1;
        in_wls   = wls;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_wls   = $urandom;
        chk("in_ready_low_after_accept", {63'd0, in_ready}, 64'd0);
        if (k_abort >= 0) begin
            out_ready = 1'b1;
            for (int i = 0; i < k_abort; i++) begin
                @(posedge clk); #1;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        cyc = 0;
        while (!in_ready && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (cyc >= 3);
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready) begin
            miscompares++;
            $display("FAIL batch_timeout: wls=%08h not finished in %0d cycles", wls, cyc);
        end
        chk("issued_cnt_after_batch", {58'd0, issued_cnt}, 64'(n));
    endtask

    // Monitor: compares every presented grant and done pulse against the scoreboard queues.
    always @(negedge clk) begin
        bit          nxt;
        grant_t      g;
        int          e;
        logic [31:0] oh;
        if (rst) begin
            done_exp = 1'b0;
        end else begin
            nxt = 1'b0;
            chk("done_timing", {63'd0, done}, {63'd0, done_exp});
            if (done) begin
                if (cnt_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL done_unexpected: issued_cnt %0d with no batch outstanding", issued_cnt);
                end else begin
                    e = cnt_q.pop_front();
                    chk("done_issued_cnt", {58'd0, issued_cnt}, 64'(e));
                end
            end
            chk("in_ready_state", {63'd0, in_ready}, {63'd0, !(out_valid || done)});
            if (out_valid) begin
                if (abort) begin
                    nxt = 1'b1;
                end else if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_unexpected: out_addr %0d with empty scoreboard", out_addr);
                end else begin
                    g  = exp_q[0];
                    oh = 32'd1 << g.addr;
                    chk("out_addr", {59'd0, out_addr}, 64'(g.addr));
                    chk("out_wl", {32'd0, out_wl}, {32'd0, oh});
                    chk("out_last", {63'd0, out_last}, {63'd0, g.last});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        nxt = g.last;
                    end
                end
            end else begin
                chk("idle_out_wl", {32'd0, out_wl}, 64'd0);
                chk("idle_out_addr", {59'd0, out_addr}, 64'd0);
                chk("idle_out_last", {63'd0, out_last}, 64'd0);
            end
            if (in_valid && in_ready && in_wls == 32'd0) nxt = 1'b1;
            done_exp = nxt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_wl"}, {32'd0, out_wl}, 64'd0);
        chk({tag, "_out_addr"}, {59'd0, out_addr}, 64'd0);
        chk({tag, "_out_last"}, {63'd0, out_last}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_issued_cnt"}, {58'd0, issued_cnt}, 64'd0);
    endtask

    initial begin
        int          n;
        int          k;
        int          cnt1;
        logic [31:0] w;
        vectors     = 0;
        miscompares = 0;
        done_exp    = 1'b0;
        m_ptr       = 31;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_wls      = 32'd0;
        abort       = 1'b0;
        out_ready   = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_batch(32'h0000_0001, 0, -1);
        run_batch(32'h8000_0011, 0, -1);
        run_batch(32'h0000_0030, 2, -1);
        run_batch(32'h0000_0021, 2, -1);
        run_batch(32'h0000_0000, 0, -1);
        run_batch(32'hFFFF_FFFF, 0, -1);
        run_batch(32'h0000_000F, 0, 2);
        run_batch(32'h0000_0006, 1, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       w = $urandom;
                1:       w = $urandom & $urandom & $urandom;
                2:       w = 32'd1 << $urandom_range(0, 31);
                default: w = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & $urandom);
            endcase
            cnt1 = $countones(w);
            k    = (cnt1 > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, cnt1 - 1) : -1;
            run_batch(w, (t % 3 == 2) ? 0 : 1, k);
        end

        wait_ready();
        push_plan(32'h0000_FF00, -1, n);
        in_valid = 1'b1;
        in_wls   = 32'h0000_FF00;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_reset_outputs("midbatch_reset");
        exp_q.delete();
        cnt_q.delete();
        m_ptr = 31;
        @(posedge clk); #1;
        rst = 1'b0;
        run_batch(32'h0000_0104, 1, -1);
        run_batch(32'h4000_0002, 0, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_grants_drained", 64'(exp_q.size()), 64'd0);
        chk("scoreboard_done_drained", 64'(cnt_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
